// File: rtl/if_stage_fq.sv
// Instruction-fetch stage with an in-order fetch queue, multiple requests in flight and redirect flush.
// Define FQ_PERF_EN to add saturating 32-bit performance counters.
module if_stage_fq #(
    parameter int              PC_W     = 64,
    parameter int              INST_W   = 32,
    parameter int              PC_STEP  = 1,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ds_allowin,
    input  logic [PC_W:0]          br_bus,
    output logic                   fs_to_ds_valid,
    output logic [INST_W+PC_W-1:0] fs_to_ds_bus,
    output logic                   inst_req_valid,
    input  logic                   inst_req_ready,
    output logic [PC_W-1:0]        inst_req_addr,
    input  logic                   inst_resp_valid,
    input  logic [INST_W-1:0]      inst_resp_data
`ifdef FQ_PERF_EN
    ,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_flush_cnt,
    output logic [31:0]            perf_drop_cnt,
    output logic [31:0]            perf_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = $clog2(FQ_DEPTH + 1);
    // Stale requests left over from a flush can coexist with a full queue of new ones,
    // so the in-flight counters get headroom beyond FQ_DEPTH.
    localparam int OUT_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FQ_DEPTH);

    logic              br_taken;
    logic [PC_W-1:0]   br_target;
    logic [PC_W-1:0]   fetch_pc;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  fill_ptr;
    logic [CNT_W-1:0]  count;
    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  discard;
    logic [FQ_DEPTH-1:0] slot_filled;
    logic [PC_W-1:0]   slot_pc   [FQ_DEPTH];
    logic [INST_W-1:0] slot_inst [FQ_DEPTH];
    logic push;
    logic pop;
    logic resp_hit;
    logic drop;
    logic fill;

    assign br_taken  = br_bus[PC_W];
    assign br_target = br_bus[PC_W-1:0];

    // Request credit depends only on registered count, never on ds_allowin.
    always_comb begin
        inst_req_valid = !reset && !br_taken && (count < FULL);
        inst_req_addr  = reset ? RESET_PC : fetch_pc;
        fs_to_ds_valid = !reset && (count != '0) && slot_filled[head];
        fs_to_ds_bus   = {slot_inst[head], slot_pc[head]};
        push           = inst_req_valid && inst_req_ready;
        pop            = fs_to_ds_valid && ds_allowin && !br_taken;
        resp_hit       = !reset && inst_resp_valid && (outstanding != '0);
        drop           = resp_hit && (br_taken || (discard != '0));
        fill           = resp_hit && !drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            fill_ptr    <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            slot_filled <= '0;
        end else begin
            outstanding <= outstanding + OUT_W'(push) - OUT_W'(resp_hit);
            if (br_taken) begin
                fetch_pc <= br_target;
                head     <= '0;
                tail     <= '0;
                fill_ptr <= '0;
                count    <= '0;
                discard  <= outstanding - OUT_W'(resp_hit);
            end else begin
                if (push) begin
                    slot_filled[tail] <= 1'b0;
                    tail              <= tail + PTR_W'(1);
                    fetch_pc          <= fetch_pc + PC_W'(PC_STEP);
                end
                if (fill) begin
                    slot_filled[fill_ptr] <= 1'b1;
                    fill_ptr              <= fill_ptr + PTR_W'(1);
                end
                if (drop) begin
                    discard <= discard - OUT_W'(1);
                end
                if (pop) begin
                    head <= head + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            slot_pc[tail] <= fetch_pc;
        end
        if (fill) begin
            slot_inst[fill_ptr] <= inst_resp_data;
        end
    end

`ifdef FQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_drop_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push && (perf_fetch_cnt != '1)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (br_taken && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
            if (drop && (perf_drop_cnt != '1)) begin
                perf_drop_cnt <= perf_drop_cnt + 32'd1;
            end
            if ((count == FULL) && !fs_to_ds_valid && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage_fq.sv
// Bench for if_stage_fq: vector table, directed redirect/wrap/reset sequences and randomized traffic
// against a queue-based reference model with an in-order variable-latency memory.
module tb_if_stage_fq;

    localparam int          PC_W     = 64;
    localparam int          INST_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          PC_STEP  = 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   ds_allowin;
    logic [PC_W:0]          br_bus;
    logic                   fs_to_ds_valid;
    logic [INST_W+PC_W-1:0] fs_to_ds_bus;
    logic                   inst_req_valid;
    logic                   inst_req_ready;
    logic [PC_W-1:0]        inst_req_addr;
    logic                   inst_resp_valid;
    logic [INST_W-1:0]      inst_resp_data;
`ifdef FQ_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_flush_cnt, perf_drop_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    if_stage_fq #(
        .PC_W(PC_W), .INST_W(INST_W), .PC_STEP(PC_STEP), .RESET_PC(RESET_PC), .FQ_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ds_allowin(ds_allowin),
        .br_bus(br_bus),
        .fs_to_ds_valid(fs_to_ds_valid),
        .fs_to_ds_bus(fs_to_ds_bus),
        .inst_req_valid(inst_req_valid),
        .inst_req_ready(inst_req_ready),
        .inst_req_addr(inst_req_addr),
        .inst_resp_valid(inst_resp_valid),
        .inst_resp_data(inst_resp_data)
`ifdef FQ_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_flush_cnt(perf_flush_cnt),
        .perf_drop_cnt(perf_drop_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        bit          filled;
    } entry_t;

    typedef struct {
        logic [63:0] addr;
        int          due;
        logic [31:0] data;
    } mreq_t;

    typedef struct {
        bit          rst;
        bit          allowin;
        bit          ready;
        bit          exp_rv;
        logic [63:0] exp_addr;
        bit          exp_fv;
        logic [63:0] exp_pc;
    } vec_t;

    // Reference model: the fetch queue is a plain list of pending instructions.
    entry_t      fq[$];
    logic [63:0] m_pc = RESET_PC;
    int          m_out = 0;
    int          m_disc = 0;

    // Memory: in-order, each response due no earlier than lat cycles after acceptance.
    mreq_t mq[$];
    int    cyc = 0;
    int    last_due = 0;
    int    mem_lat = 1;
    int    lat_jitter = 0;
    bit    mem_reset_clears = 1'b1;
    int    seq = 0;

    logic        s_rv;
    logic        s_fv;
    logic [63:0] s_addr;
    logic [95:0] s_bus;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit allowin, input bit ready,
                                 input bit br, input logic [63:0] target);
        bit          exp_rv;
        bit          exp_fv;
        logic [63:0] exp_addr;
        bit          hit;
        int          due;
        int          idx;
        @(negedge clk);
        reset          = rst;
        ds_allowin     = allowin;
        inst_req_ready = ready;
        br_bus         = {br, target};
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            inst_resp_valid = 1'b1;
            inst_resp_data  = mq[0].data;
            void'(mq.pop_front());
        end else begin
            inst_resp_valid = 1'b0;
            inst_resp_data  = $urandom;
        end
        #1;
        s_rv   = inst_req_valid;
        s_fv   = fs_to_ds_valid;
        s_addr = inst_req_addr;
        s_bus  = fs_to_ds_bus;

        exp_rv   = !rst && !br && (fq.size() < DEPTH);
        exp_addr = rst ? RESET_PC : m_pc;
        exp_fv   = !rst && (fq.size() > 0) && fq[0].filled;
        checkOutput("req_valid", s_rv, exp_rv);
        checkOutput("req_addr", s_addr, exp_addr);
        checkOutput("fs_valid", s_fv, exp_fv);
        if (exp_fv) checkOutput("fs_bus", s_bus, {fq[0].inst, fq[0].pc});

        if (rst) begin
            fq.delete();
            m_pc   = RESET_PC;
            m_out  = 0;
            m_disc = 0;
            if (mem_reset_clears) begin
                mq.delete();
                last_due = 0;
            end
        end else begin
            hit = inst_resp_valid && (m_out > 0);
            if (br) begin
                fq.delete();
                m_pc = target;
                if (hit) m_out--;
                m_disc = m_out;
            end else begin
                if (hit) begin
                    m_out--;
                    if (m_disc > 0) begin
                        m_disc--;
                    end else begin
                        idx = -1;
                        for (int i = 0; i < fq.size(); i++)
                            if (idx < 0 && !fq[i].filled) idx = i;
                        if (idx >= 0) begin
                            fq[idx].inst   = inst_resp_data;
                            fq[idx].filled = 1'b1;
                        end
                    end
                end
                if (exp_fv && allowin) void'(fq.pop_front());
                if (exp_rv && ready) begin
                    fq.push_back('{m_pc, 32'h0, 1'b0});
                    m_pc  = m_pc + 64'(PC_STEP);
                    m_out++;
                end
            end
        end

        if (s_rv && ready) begin
            due = cyc + mem_lat + ((lat_jitter > 0) ? $urandom_range(0, lat_jitter) : 0);
            if (due <= last_due) due = last_due + 1;
            mq.push_back('{s_addr, due, {seq[15:0], s_addr[15:0]}});
            last_due = due;
            seq++;
        end
        cyc++;
    endtask

    task automatic addVec(input bit rst, input bit allowin, input bit ready, input bit rv,
                          input logic [63:0] addr, input bit fv, input logic [63:0] pc);
        vecs.push_back('{rst, allowin, ready, rv, addr, fv, pc});
    endtask

    initial begin
        bit          seen;
        int          exp_seq;
        logic [63:0] tgt;
        reset           = 1'b1;
        ds_allowin      = 1'b0;
        inst_req_ready  = 1'b0;
        br_bus          = '0;
        inst_resp_valid = 1'b0;
        inst_resp_data  = '0;

        // Streaming at full rate, then a blocked consumer filling the queue and draining in order.
        addVec(1, 1, 1, 0, 0, 0, 0);
        addVec(1, 1, 1, 0, 0, 0, 0);
        addVec(0, 1, 1, 1, 0, 0, 0);
        addVec(0, 1, 1, 1, 1, 0, 0);
        addVec(0, 1, 1, 1, 2, 1, 0);
        addVec(0, 1, 1, 1, 3, 1, 1);
        addVec(0, 1, 1, 1, 4, 1, 2);
        addVec(0, 1, 1, 1, 5, 1, 3);
        addVec(0, 1, 1, 1, 6, 1, 4);
        addVec(0, 1, 1, 1, 7, 1, 5);
        addVec(0, 1, 1, 1, 8, 1, 6);
        addVec(1, 0, 1, 0, 0, 0, 0);
        addVec(1, 0, 1, 0, 0, 0, 0);
        addVec(0, 0, 1, 1, 0, 0, 0);
        addVec(0, 0, 1, 1, 1, 0, 0);
        addVec(0, 0, 1, 1, 2, 1, 0);
        addVec(0, 0, 1, 1, 3, 1, 0);
        addVec(0, 0, 1, 0, 4, 1, 0);
        addVec(0, 0, 1, 0, 4, 1, 0);
        addVec(0, 1, 1, 0, 4, 1, 0);
        addVec(0, 1, 1, 1, 4, 1, 1);
        addVec(0, 1, 1, 1, 5, 1, 2);
        addVec(0, 1, 1, 1, 6, 1, 3);
        addVec(0, 1, 1, 1, 7, 1, 4);

        mem_lat = 1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].allowin, vecs[i].ready, 1'b0, 64'h0);
            checkOutput("tbl_req_valid", s_rv, vecs[i].exp_rv);
            checkOutput("tbl_req_addr", s_addr, vecs[i].exp_addr);
            checkOutput("tbl_fs_valid", s_fv, vecs[i].exp_fv);
            if (vecs[i].exp_fv) checkOutput("tbl_fs_pc", s_bus[63:0], vecs[i].exp_pc);
        end

        // Redirect with three requests in flight; the oldest response lands in the redirect cycle.
        repeat (2) applyStimulus(1, 1, 1, 0, 64'h0);
        mem_lat = 3;
        repeat (3) applyStimulus(0, 1, 1, 0, 64'h0);
        applyStimulus(0, 1, 1, 1, 64'h100);
        applyStimulus(0, 1, 1, 0, 64'h0);
        checkOutput("redirect_req_valid", s_rv, 1'b1);
        checkOutput("redirect_addr", s_addr, 64'h100);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1, 1, 0, 64'h0);
            if (s_fv && !seen) begin
                seen = 1'b1;
                checkOutput("redirect_first_pc", s_bus[63:0], 64'h100);
            end
        end
        checkOutput("redirect_delivered", seen, 1'b1);

        // PC wrap through all-ones, running long enough for head/tail to wrap twice.
        tgt = 64'hFFFF_FFFF_FFFF_FFFF;
        applyStimulus(0, 1, 1, 1, tgt);
        applyStimulus(0, 1, 1, 0, 64'h0);
        checkOutput("wrap_first_addr", s_addr, tgt);
        applyStimulus(0, 1, 1, 0, 64'h0);
        checkOutput("wrap_second_addr", s_addr, 64'h0);
        checkOutput("wrap_second_valid", s_rv, 1'b1);
        repeat (2 * DEPTH + 6) applyStimulus(0, 1, 1, 0, 64'h0);

        // Reset with two requests in flight; their late responses must not be delivered.
        repeat (4) applyStimulus(1, 1, 1, 0, 64'h0);
        mem_reset_clears = 1'b0;
        repeat (2) applyStimulus(0, 1, 1, 0, 64'h0);
        repeat (2) applyStimulus(1, 1, 1, 0, 64'h0);
        applyStimulus(0, 1, 0, 0, 64'h0);
        applyStimulus(0, 1, 0, 0, 64'h0);
        exp_seq = seq;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1, 1, 0, 64'h0);
            if (s_fv && !seen) begin
                seen = 1'b1;
                checkOutput("reset_first_pc", s_bus[63:0], RESET_PC);
                checkOutput("reset_first_inst", s_bus[95:64], {exp_seq[15:0], RESET_PC[15:0]});
            end
        end
        checkOutput("reset_delivered", seen, 1'b1);
        mem_reset_clears = 1'b1;

        // Randomized traffic: stalls, back-pressure, redirects, resets and jittery latency.
        mem_lat    = 1;
        lat_jitter = 3;
        for (int i = 0; i < 3000; i++) begin
            tgt = {$urandom, $urandom};
            applyStimulus($urandom_range(0, 199) == 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
                          $urandom_range(0, 19) == 0, tgt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
